// File: rtl/crc_serial_engine.sv
// crc_serial_engine
//   Serial CRC generator/checker (EPC Gen2 CRC-16 by default, CRC-5 by parameter).
//   Accumulates one bit per qualified cycle, reports a residue match, then shifts a
//   snapshot of the (optionally complemented) CRC out MSB-first under a ready handshake.
//
// Ports
//   crcoutclk    in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   clear_i      in   synchronous re-initialise (wins over every other input)
//   bit_in_i     in   serial data bit
//   bit_valid_i  in   accumulate bit_in_i this cycle (ignored outside accumulation)
//   start_out_i  in   snapshot the CRC and begin readout
//   out_ready_i  in   consumer accepted the current bit_out_o
//   bit_out_o    out  current CRC output bit, MSB first
//   out_valid_o  out  bit_out_o is meaningful
//   crc_done_o   out  all WIDTH bits have been accepted
//   crc_ok_o     out  live register equals RESIDUE
//   crc_value_o  out  live CRC register
module crc_serial_engine #(
    parameter int unsigned WIDTH      = 16,
    parameter logic [31:0] POLY       = 32'h0000_1021,
    parameter logic [31:0] INIT       = 32'h0000_FFFF,
    parameter bit          INVERT_OUT = 1'b1,
    parameter logic [31:0] RESIDUE    = 32'h0000_1D0F
) (
    input  logic             crcoutclk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             bit_in_i,
    input  logic             bit_valid_i,
    input  logic             start_out_i,
    input  logic             out_ready_i,
    output logic             bit_out_o,
    output logic             out_valid_o,
    output logic             crc_done_o,
    output logic             crc_ok_o,
    output logic [WIDTH-1:0] crc_value_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    // Parameter bits above WIDTH-1 are dropped.
    localparam logic [WIDTH-1:0] PolyW    = POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] InitW    = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ResidueW = RESIDUE[WIDTH-1:0];
    localparam logic [CntW-1:0]  CntLast  = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StAccum = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] crc_acc;
    logic [WIDTH-1:0] snap_shifted;
    logic             fb;

    // Register value after this cycle's bit, used both for accumulation and for a
    // snapshot taken in the same cycle as the last data bit.
    always_comb begin
        fb      = 1'b0;
        crc_acc = crc_q;
        if (bit_valid_i) begin
            fb      = bit_in_i ^ crc_q[WIDTH-1];
            crc_acc = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? PolyW : '0);
        end
    end

    // Current readout bit sits at the MSB after shifting by the count.
    assign snap_shifted = snap_q << cnt_q;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        snap_d      = snap_q;
        cnt_d       = cnt_q;
        out_valid_o = 1'b0;
        crc_done_o  = 1'b0;
        bit_out_o   = 1'b0;

        case (state_q)
            StAccum: begin
                crc_d = crc_acc;
                if (start_out_i) begin
                    snap_d  = INVERT_OUT ? ~crc_acc : crc_acc;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                out_valid_o = 1'b1;
                bit_out_o   = snap_shifted[WIDTH-1];
                if (out_ready_i) begin
                    // Leave the count at its last value so it never wraps.
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                crc_done_o = 1'b1;
                bit_out_o  = snap_q[0];
            end
            default: begin
                state_d = StAccum;
            end
        endcase

        if (clear_i) begin
            state_d = StAccum;
            crc_d   = InitW;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge crcoutclk or posedge reset) begin
        if (reset) begin
            state_q <= StAccum;
            crc_q   <= InitW;
            snap_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign crc_value_o = crc_q;
    assign crc_ok_o    = (crc_q == ResidueW);

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: a CRC-16 instance (defaults) and a CRC-5 instance share
// data inputs. Readout expectations are queued at stimulus time and popped by a monitor.
module tb_crc_serial_engine;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        clear5;
    logic        bit_in;
    logic        bit_valid;
    logic        start_out;
    logic        start5;
    logic        out_ready;

    logic        bo16, ov16, done16, ok16;
    logic [15:0] val16;
    logic        bo5, ov5, done5, ok5;
    logic [4:0]  val5;

    int n_checks = 0;
    int n_fail   = 0;

    logic q16[$];
    logic q5[$];

    crc_serial_engine dut (
        .crcoutclk   (clk),
        .reset       (rst),
        .clear_i     (clear),
        .bit_in_i    (bit_in),
        .bit_valid_i (bit_valid),
        .start_out_i (start_out),
        .out_ready_i (out_ready),
        .bit_out_o   (bo16),
        .out_valid_o (ov16),
        .crc_done_o  (done16),
        .crc_ok_o    (ok16),
        .crc_value_o (val16)
    );

    crc_serial_engine #(
        .WIDTH      (5),
        .POLY       (32'h09),
        .INIT       (32'h09),
        .INVERT_OUT (1'b0),
        .RESIDUE    (32'h00)
    ) dut5 (
        .crcoutclk   (clk),
        .reset       (rst),
        .clear_i     (clear5),
        .bit_in_i    (bit_in),
        .bit_valid_i (bit_valid),
        .start_out_i (start5),
        .out_ready_i (out_ready),
        .bit_out_o   (bo5),
        .out_valid_o (ov5),
        .crc_done_o  (done5),
        .crc_ok_o    (ok5),
        .crc_value_o (val5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every accepted output bit is checked against the head of its queue.
    always @(negedge clk) begin
        if (!rst && ov16 && out_ready) begin
            if (q16.size() == 0) begin
                chk("bit16_unexpected", 32'(bo16), 32'hX);
            end else begin
                chk("bit16", 32'(bo16), 32'(q16.pop_front()));
            end
        end
        if (!rst && ov5 && out_ready) begin
            if (q5.size() == 0) begin
                chk("bit5_unexpected", 32'(bo5), 32'hX);
            end else begin
                chk("bit5", 32'(bo5), 32'(q5.pop_front()));
            end
        end
    end

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    // ASCII "123456789", MSB-first; optionally flip one bit; send only the first nbits.
    task automatic send_frame(input int flip, input int nbits);
        logic [7:0] byte_v;
        logic       b;
        int         idx;
        idx = 0;
        for (int i = 0; i < 9; i++) begin
            byte_v = 8'h31 + 8'(i);
            for (int j = 7; j >= 0; j--) begin
                b = byte_v[j];
                if (idx == flip) b = ~b;
                if (idx < nbits) send_bit(b);
                idx++;
            end
        end
    endtask

    task automatic send_word16(input logic [15:0] w);
        for (int j = 15; j >= 0; j--) send_bit(w[j]);
    endtask

    task automatic push16(input logic [15:0] w, input int n);
        for (int j = 15; j > 15 - n; j--) q16.push_back(w[j]);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic start(input logic s16, input logic s5);
        start_out = s16;
        start5    = s5;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start_out = 1'b0;
        start5    = 1'b0;
    endtask

    // Run the readout from SHIFT entry; cycles counts edges until crc_done.
    task automatic readout(input bit toggle, output int cycles);
        cycles = 0;
        while (!done16 && cycles < 100) begin
            out_ready = toggle ? cycles[0] : 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        out_ready = 1'b0;
        if (!done16) chk("done_timeout", 32'(done16), 32'h1);
    endtask

    int cyc;

    initial begin
        rst = 1'b1; clear = 1'b0; clear5 = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        start_out = 1'b0; start5 = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_value16", 32'(val16), 32'hFFFF);
        chk("rst_ok16", 32'(ok16), 32'h0);
        chk("rst_valid16", 32'(ov16), 32'h0);
        chk("rst_done16", 32'(done16), 32'h0);
        chk("rst_bitout16", 32'(bo16), 32'h0);
        chk("rst_value5", 32'(val5), 32'h09);
        chk("rst_ok5", 32'(ok5), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Check string through both engines, then read both out.
        send_frame(-1, 72);
        chk("frame_value16", 32'(val16), 32'h29B1);
        chk("frame_ok16", 32'(ok16), 32'h0);
        chk("frame_value5", 32'(val5), 32'h00);
        chk("frame_ok5", 32'(ok5), 32'h1);
        push16(16'hD64E, 16);
        for (int j = 0; j < 5; j++) q5.push_back(1'b0);
        start(1'b1, 1'b1);
        readout(1'b0, cyc);
        chk("held_cycles", 32'(cyc), 32'd16);
        chk("done16", 32'(done16), 32'h1);
        chk("done_valid16", 32'(ov16), 32'h0);
        chk("done_bitout16", 32'(bo16), 32'h0);
        chk("done_value16", 32'(val16), 32'h29B1);
        chk("done5", 32'(done5), 32'h1);
        chk("q16_drained", 32'(q16.size()), 32'h0);
        chk("q5_drained", 32'(q5.size()), 32'h0);
        // start_out in DONE is ignored.
        start(1'b1, 1'b0);
        chk("restart_ignored", 32'(done16), 32'h1);

        // Residue check: frame followed by its transmitted CRC.
        do_clear();
        chk("clear_done16", 32'(done16), 32'h0);
        send_frame(-1, 72);
        send_word16(16'hD64E);
        chk("residue_value", 32'(val16), 32'h1D0F);
        chk("residue_ok", 32'(ok16), 32'h1);
        do_clear();
        send_frame(5, 72);
        send_word16(16'hD64E);
        chk("corrupt_ok", 32'(ok16), 32'h0);

        // Empty frame.
        do_clear();
        push16(16'h0000, 16);
        start(1'b1, 1'b0);
        readout(1'b0, cyc);
        chk("empty_cycles", 32'(cyc), 32'd16);

        // Toggled ready over a non-trivial pattern.
        do_clear();
        send_frame(-1, 72);
        push16(16'hD64E, 16);
        start(1'b1, 1'b0);
        readout(1'b1, cyc);
        chk("toggle_cycles", 32'(cyc), 32'd32);
        chk("toggle_drained", 32'(q16.size()), 32'h0);

        // Last data bit in the same cycle as start_out; bit_valid ignored in SHIFT.
        do_clear();
        send_frame(-1, 71);
        push16(16'hD64E, 16);
        bit_in = 1'b1; bit_valid = 1'b1; start_out = 1'b1;
        @(posedge clk); #1;
        start_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("shift_frozen", 32'(val16), 32'h29B1);
        chk("shift_valid", 32'(ov16), 32'h1);
        bit_valid = 1'b0;
        readout(1'b0, cyc);
        chk("same_cycle_drained", 32'(q16.size()), 32'h0);

        // clear together with out_ready at cnt = 7.
        do_clear();
        push16(16'h0000, 8);
        start(1'b1, 1'b0);
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        chk("clr_valid", 32'(ov16), 32'h0);
        chk("clr_done", 32'(done16), 32'h0);
        chk("clr_value", 32'(val16), 32'hFFFF);
        chk("clr_drained", 32'(q16.size()), 32'h0);
        send_bit(1'b1);
        chk("clr_accum", 32'(val16), 32'hFFFE);

        // Asynchronous reset mid-SHIFT.
        do_clear();
        send_frame(-1, 72);
        push16(16'hD64E, 3);
        start(1'b1, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("pre_rst_bitout", 32'(bo16), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ov16), 32'h0);
        chk("arst_bitout", 32'(bo16), 32'h0);
        chk("arst_done", 32'(done16), 32'h0);
        chk("arst_value", 32'(val16), 32'hFFFF);
        chk("arst_drained", 32'(q16.size()), 32'h0);
        #4 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Parametrised serial CRC generator/checker for the tag's backscatter and command paths. One engine covers EPC Gen2 CRC-16 (default) and CRC-5 by parameter choice.
- Accumulates one bit per qualified cycle, flags a residue match for received frames, then shifts the (optionally complemented) CRC out MSB-first under a ready handshake.
- Single clock domain. Sits between the command decoder / packet builder and the modulator.

Parameters:
- WIDTH, 16, CRC length in bits; legal range 5..32.
- POLY, 16'h1021, generator polynomial without the implicit x^WIDTH term.
- INIT, 16'hFFFF, register value at reset and on clear.
- INVERT_OUT, 1, 1 = transmit ones' complement of the register; 0 = transmit the register as is.
- RESIDUE, 16'h1D0F, register value that indicates a good received frame (CRC bits included).

Ports:
- crcoutclk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; returns all state to reset values.
- clear  in  1  synchronous re-initialise; highest priority after reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is accumulated this cycle.
- start_out  in  1  snapshot the CRC and begin readout.
- out_ready  in  1  consumer accepted the current bit_out.
- bit_out  out  1  current CRC output bit, MSB first.
- out_valid  out  1  bit_out is meaningful.
- crc_done  out  1  all WIDTH bits have been accepted.
- crc_ok  out  1  register equals RESIDUE.
- crc_value  out  WIDTH  live CRC register, for debug and parallel use.

Behaviour:
- Reset and interface:
  - Reset: asynchronous, active-high; clock crcoutclk.
  - Reset values: register = INIT, state = ACCUM, cnt = 0, snapshot = 0.
  - Reset output values: out_valid = 0, crc_done = 0, bit_out = 0, crc_value = INIT, crc_ok = (INIT == RESIDUE).
- States: ACCUM, SHIFT, DONE. Held in a 2-bit state register; the unused encoding recovers to ACCUM.
- ACCUM update:
  - On bit_valid: fb = bit_in ^ r[WIDTH-1]; r <= {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY : 0).
  - Latency is 1 cycle; the new value is visible on crc_value the next cycle.
  - When bit_valid = 0, r holds.
- crc_ok is combinational from r and valid in every state.
- start_out in ACCUM:
  - snapshot <= INVERT_OUT ? ~r_next : r_next, where r_next includes a same-cycle bit_valid.
  - cnt <= 0; state <= SHIFT.
- SHIFT:
  - out_valid = 1; bit_out = snapshot[WIDTH-1-cnt].
  - On out_ready, cnt increments.
  - If out_ready with cnt == WIDTH-1, go to DONE.
  - bit_valid and start_out are ignored; r is frozen.
- DONE:
  - crc_done = 1, out_valid = 0, bit_out holds snapshot[0].
  - Stays in DONE until clear or reset.
- clear: in any state, next cycle r = INIT, state = ACCUM, cnt = 0, crc_done = 0, out_valid = 0.
  - clear wins over a same-cycle bit_valid, start_out or out_ready.
- start_out while in SHIFT or DONE is ignored; there is no restart without clear.
- Counter width is $clog2(WIDTH). It never wraps because DONE stops it.
- Reset asserted mid-SHIFT aborts the readout immediately (asynchronously); no partial crc_done.
- out_ready held high during SHIFT gives one bit per cycle: WIDTH cycles from SHIFT entry to crc_done.
- Parameters with nonzero bits above WIDTH-1 are truncated to WIDTH bits.

Test Plan:
- Defaults; reset; feed ASCII "123456789" MSB-first (72 bits); start_out; out_ready held high -> bit_out sequence 0xD64E, crc_done = 1 exactly 16 cycles after SHIFT entry, crc_value = 0x29B1 (not inverted).
- Same frame followed by the 16 bits 0xD64E, no start_out -> crc_value = 0x1D0F, crc_ok = 1. Flip one data bit -> crc_ok = 0.
- WIDTH=5, POLY=5'h09, INIT=5'h09, INVERT_OUT=0, RESIDUE=0; feed "123456789" -> crc_value = 5'h00, crc_ok = 1; readout gives 00000.
- Empty frame at defaults, start_out immediately -> output 0x0000, crc_done after 16 accepted bits. Toggle out_ready every other cycle -> 32 cycles to crc_done, with no bit skipped or repeated.
- bit_valid and start_out in the same cycle -> snapshot includes that bit. bit_valid during SHIFT -> crc_value unchanged.
- clear in the same cycle as out_ready at cnt = 7 -> next cycle state ACCUM, out_valid = 0, crc_value = 0xFFFF. Async reset mid-SHIFT -> outputs return to reset values without waiting for a clock edge.
